// File: rtl/cache_pkg.sv
// Shared geometry, line/state types and the address splitter for the L1 instruction cache.
package cache_pkg;

  localparam int unsigned ADDR_SIZE      = 64;
  localparam int unsigned BYTES_PER_LINE = 64;
  localparam int unsigned DATA_SIZE      = BYTES_PER_LINE * 8;
  localparam int unsigned OFFSET_SIZE    = $clog2(BYTES_PER_LINE);
  localparam int unsigned LINE_ADDR_SIZE = ADDR_SIZE - OFFSET_SIZE;
  localparam int unsigned WORD_SEL_SIZE  = OFFSET_SIZE - 2;
  localparam int unsigned INST_SIZE      = 32;

  // Tag is carried right-aligned at its widest possible size; users slice to their TAG_SIZE.
  typedef struct packed {
    logic                      valid;
    logic [LINE_ADDR_SIZE-1:0] tag;
    logic [DATA_SIZE-1:0]      data;
  } icache_line_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    RESPOND = 2'd2
  } icache_state_t;

  typedef struct packed {
    logic [LINE_ADDR_SIZE-1:0] tag;
    logic [LINE_ADDR_SIZE-1:0] index;
    logic [WORD_SEL_SIZE-1:0]  word;
  } addr_fields_t;

  function automatic addr_fields_t addr_split(input logic [ADDR_SIZE-1:0] addr,
                                              input int unsigned          index_size);
    addr_fields_t              f;
    logic [LINE_ADDR_SIZE-1:0] line;
    line    = addr[ADDR_SIZE-1:OFFSET_SIZE];
    f.tag   = line >> index_size;
    f.index = line & ((LINE_ADDR_SIZE'(1) << index_size) - LINE_ADDR_SIZE'(1));
    f.word  = addr[OFFSET_SIZE-1:2];
    return f;
  endfunction

endpackage

// File: rtl/l1_icache_array.sv
// Direct-mapped line storage: async-cleared valid bits, combinational lookup, synchronous fill.
module l1_icache_array
  import cache_pkg::*;
#(
  parameter int unsigned LINE_COUNT = 32,
  parameter int unsigned INDEX_SIZE = $clog2(LINE_COUNT),
  parameter int unsigned TAG_SIZE   = ADDR_SIZE - INDEX_SIZE - OFFSET_SIZE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_all,
  input  logic [INDEX_SIZE-1:0]    lookup_index,
  input  logic [TAG_SIZE-1:0]      lookup_tag,
  input  logic [WORD_SEL_SIZE-1:0] lookup_word,
  output logic                     lookup_hit,
  output logic [INST_SIZE-1:0]     lookup_inst,
  input  logic                     fill_en,
  input  logic [INDEX_SIZE-1:0]    fill_index,
  input  icache_line_t             fill_line
);

  logic [LINE_COUNT-1:0] r_valid;
  logic [TAG_SIZE-1:0]   r_tag  [LINE_COUNT];
  logic [DATA_SIZE-1:0]  r_data [LINE_COUNT];
  logic [DATA_SIZE-1:0]  w_line;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else if (flush_all) begin
      r_valid <= '0;
    end else if (fill_en) begin
      r_valid[fill_index] <= fill_line.valid;
    end
  end

  // Tag/data are deliberately left unreset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      r_tag[fill_index]  <= fill_line.tag[TAG_SIZE-1:0];
      r_data[fill_index] <= fill_line.data;
    end
  end

  always_comb begin
    w_line      = r_data[lookup_index];
    lookup_hit  = r_valid[lookup_index] && (r_tag[lookup_index] == lookup_tag);
    lookup_inst = w_line[{lookup_word, 5'd0} +: INST_SIZE];
  end

endmodule

// File: rtl/l1_icache.sv
// L1 instruction cache top: fetch handshake FSM, LLC line fill, flush sequencing and perf counters.
module l1_icache
  import cache_pkg::*;
#(
  parameter int unsigned LINE_COUNT = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [ADDR_SIZE-1:0]  req_addr,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [INST_SIZE-1:0]  resp_inst,
  input  logic                  resp_ready,
  input  logic                  flush,
  output logic [ADDR_SIZE-1:0]  llc_r_addr,
  output logic                  llc_r_addr_valid,
  input  logic [DATA_SIZE-1:0]  llc_r_data,
  input  logic                  llc_r_data_valid,
  output logic [31:0]           perf_hits,
  output logic [31:0]           perf_misses
);

  localparam int unsigned INDEX_SIZE = $clog2(LINE_COUNT);
  localparam int unsigned TAG_SIZE   = ADDR_SIZE - INDEX_SIZE - OFFSET_SIZE;

  icache_state_t          r_state;
  icache_state_t          w_state_next;
  logic [ADDR_SIZE-1:0]   r_addr;
  logic [INST_SIZE-1:0]   r_resp_inst;
  logic                   r_flush_pending;
  logic [31:0]            r_hits;
  logic [31:0]            r_misses;

  addr_fields_t           w_req_split;
  addr_fields_t           w_lat_split;
  logic                   w_accept;
  logic                   w_fill;
  logic                   w_flush_all;
  logic                   w_hit;
  logic [INST_SIZE-1:0]   w_lookup_inst;
  logic [INST_SIZE-1:0]   w_fill_inst;
  icache_line_t           w_fill_line;

  assign w_req_split = addr_split(req_addr, INDEX_SIZE);
  assign w_lat_split = addr_split(r_addr, INDEX_SIZE);

  l1_icache_array #(
    .LINE_COUNT (LINE_COUNT),
    .INDEX_SIZE (INDEX_SIZE),
    .TAG_SIZE   (TAG_SIZE)
  ) u_array (
    .clk          (clk),
    .reset        (reset),
    .flush_all    (w_flush_all),
    .lookup_index (w_req_split.index[INDEX_SIZE-1:0]),
    .lookup_tag   (w_req_split.tag[TAG_SIZE-1:0]),
    .lookup_word  (w_req_split.word),
    .lookup_hit   (w_hit),
    .lookup_inst  (w_lookup_inst),
    .fill_en      (w_fill),
    .fill_index   (w_lat_split.index[INDEX_SIZE-1:0]),
    .fill_line    (w_fill_line)
  );

  assign w_fill_line = '{valid: 1'b1, tag: w_lat_split.tag, data: llc_r_data};
  assign w_fill_inst = llc_r_data[{w_lat_split.word, 5'd0} +: INST_SIZE];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next     = r_state;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    llc_r_addr_valid = 1'b0;
    w_accept         = 1'b0;
    w_fill           = 1'b0;
    w_flush_all      = 1'b0;
    unique case (r_state)
      IDLE: begin
        // A pending or fresh flush takes this IDLE cycle; no request is accepted alongside it.
        w_flush_all = flush || r_flush_pending;
        req_ready   = !reset && !w_flush_all;
        w_accept    = req_valid && req_ready;
        if (w_accept) w_state_next = w_hit ? RESPOND : FILL;
      end
      FILL: begin
        llc_r_addr_valid = 1'b1;
        w_fill           = llc_r_data_valid;
        if (llc_r_data_valid) w_state_next = RESPOND;
      end
      RESPOND: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr          <= '0;
      r_resp_inst     <= '0;
      r_flush_pending <= 1'b0;
      r_hits          <= '0;
      r_misses        <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= req_addr;
        if (w_hit) begin
          r_resp_inst <= w_lookup_inst;
          r_hits      <= r_hits + 32'd1;
        end else begin
          r_misses    <= r_misses + 32'd1;
        end
      end else if (w_fill) begin
        r_resp_inst <= w_fill_inst;
      end

      if (r_state == IDLE)     r_flush_pending <= 1'b0;
      else if (flush)          r_flush_pending <= 1'b1;
    end
  end

  assign llc_r_addr  = llc_r_addr_valid
                     ? {w_lat_split.tag[TAG_SIZE-1:0], w_lat_split.index[INDEX_SIZE-1:0],
                        {OFFSET_SIZE{1'b0}}}
                     : '0;
  assign resp_inst   = r_resp_inst;
  assign perf_hits   = r_hits;
  assign perf_misses = r_misses;

endmodule

// File: tb/tb_l1_icache.sv
// Directed bench for l1_icache: miss/hit, conflict, backpressure, flush and async reset.
module tb_l1_icache;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic [63:0]  req_addr;
  logic         req_ready;
  logic         resp_valid;
  logic [31:0]  resp_inst;
  logic         resp_ready;
  logic         flush;
  logic [63:0]  llc_r_addr;
  logic         llc_r_addr_valid;
  logic [511:0] llc_r_data;
  logic         llc_r_data_valid;
  logic [31:0]  perf_hits;
  logic [31:0]  perf_misses;

  int n_cmp = 0;
  int n_err = 0;

  l1_icache #(.LINE_COUNT(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_addr         (req_addr),
    .req_ready        (req_ready),
    .resp_valid       (resp_valid),
    .resp_inst        (resp_inst),
    .resp_ready       (resp_ready),
    .flush            (flush),
    .llc_r_addr       (llc_r_addr),
    .llc_r_addr_valid (llc_r_addr_valid),
    .llc_r_data       (llc_r_data),
    .llc_r_data_valid (llc_r_data_valid),
    .perf_hits        (perf_hits),
    .perf_misses      (perf_misses)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk_line(input logic [31:0] base);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [63:0] a);
    req_addr  = a;
    req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic llc_return(input logic [31:0] base);
    llc_r_data       = mk_line(base);
    llc_r_data_valid = 1'b1;
    cyc();
    llc_r_data_valid = 1'b0;
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    cyc();
    resp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0; flush = 1'b0;
    llc_r_data = '0; llc_r_data_valid = 1'b0;
    cyc(); cyc();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_inst", resp_inst, 0);
    chk("rst_llc_valid", llc_r_addr_valid, 0);
    chk("rst_llc_addr", llc_r_addr, 0);
    chk("rst_hits", perf_hits, 0);
    chk("rst_misses", perf_misses, 0);
    reset = 1'b0;
    #1;
    chk("idle_req_ready", req_ready, 1);

    // Cold miss on 0x1000
    fetch(64'h1000);
    chk("miss1_llc_valid", llc_r_addr_valid, 1);
    chk("miss1_llc_addr", llc_r_addr, 64'h1000);
    chk("miss1_req_ready", req_ready, 0);
    cyc(); cyc();
    chk("miss1_llc_hold_valid", llc_r_addr_valid, 1);
    chk("miss1_llc_hold_addr", llc_r_addr, 64'h1000);
    chk("miss1_no_resp", resp_valid, 0);
    llc_return(32'h100);
    chk("miss1_resp_valid", resp_valid, 1);
    chk("miss1_resp_inst", resp_inst, 32'h100);
    chk("miss1_llc_drop", llc_r_addr_valid, 0);
    chk("miss1_misses", perf_misses, 1);
    consume();
    chk("miss1_done", resp_valid, 0);
    chk("miss1_ready_again", req_ready, 1);

    // Hit on 0x1004
    fetch(64'h1004);
    chk("hit1_resp_valid", resp_valid, 1);
    chk("hit1_resp_inst", resp_inst, 32'h101);
    chk("hit1_no_llc", llc_r_addr_valid, 0);
    chk("hit1_hits", perf_hits, 1);
    consume();

    // Conflict: same index, different tag
    fetch(64'h1800);
    chk("conf_llc_valid", llc_r_addr_valid, 1);
    chk("conf_llc_addr", llc_r_addr, 64'h1800);
    chk("conf_misses", perf_misses, 2);
    llc_return(32'h200);
    chk("conf_resp_inst", resp_inst, 32'h200);
    consume();
    fetch(64'h1000);
    chk("refetch_llc_valid", llc_r_addr_valid, 1);
    chk("refetch_misses", perf_misses, 3);
    llc_return(32'h100);
    consume();

    // Backpressure on a hit
    fetch(64'h1008);
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_resp_inst", resp_inst, 32'h102);
      chk("bp_req_ready", req_ready, 0);
      cyc();
    end
    chk("bp_hits", perf_hits, 2);
    consume();
    chk("bp_done", resp_valid, 0);

    // Flush during FILL
    fetch(64'h2000);
    chk("fl_miss_llc_valid", llc_r_addr_valid, 1);
    chk("fl_misses", perf_misses, 4);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("fl_fill_continues", llc_r_addr_valid, 1);
    llc_return(32'h300);
    chk("fl_resp_inst", resp_inst, 32'h300);
    consume();
    chk("fl_pending_blocks", req_ready, 0);
    cyc();
    chk("fl_applied_ready", req_ready, 1);
    fetch(64'h2004);
    chk("fl_after_miss", llc_r_addr_valid, 1);
    chk("fl_after_misses", perf_misses, 5);
    llc_return(32'h300);
    chk("fl_after_inst", resp_inst, 32'h301);
    consume();

    // Flush wins over a simultaneous request
    req_addr = 64'h2008; req_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flreq_ready", req_ready, 0);
    cyc();
    req_valid = 1'b0; flush = 1'b0;
    chk("flreq_no_resp", resp_valid, 0);
    chk("flreq_no_llc", llc_r_addr_valid, 0);
    chk("flreq_hits", perf_hits, 2);
    fetch(64'h2008);
    chk("flreq_refetch_miss", llc_r_addr_valid, 1);
    chk("flreq_misses", perf_misses, 6);
    llc_return(32'h300);
    chk("flreq_inst", resp_inst, 32'h302);
    consume();

    // Async reset mid-FILL with a stalled LLC
    fetch(64'h3000);
    chk("ar_misses", perf_misses, 7);
    for (int i = 0; i < 10; i++) cyc();
    chk("ar_stall_valid", llc_r_addr_valid, 1);
    chk("ar_stall_addr", llc_r_addr, 64'h3000);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_llc_drop", llc_r_addr_valid, 0);
    chk("ar_llc_addr", llc_r_addr, 0);
    chk("ar_req_ready", req_ready, 0);
    chk("ar_misses_clr", perf_misses, 0);
    cyc();
    reset = 1'b0;
    #1;
    chk("ar_ready", req_ready, 1);
    fetch(64'h3000);
    chk("ar_refetch_miss", llc_r_addr_valid, 1);
    chk("ar_refetch_addr", llc_r_addr, 64'h3000);
    chk("ar_refetch_misses", perf_misses, 1);
    llc_return(32'h400);
    chk("ar_refetch_inst", resp_inst, 32'h400);
    consume();
    fetch(64'h3004);
    chk("ar_hit_inst", resp_inst, 32'h401);
    chk("ar_hit_hits", perf_hits, 1);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/l1_icache.md
Name: l1_icache

Overview:
- Direct-mapped, read-only L1 instruction cache between the fetch stage and the LLC read port.
- Serves 32-bit instruction fetches.
- On a miss, requests the full 512-bit line from the LLC over the LLC read-request protocol and fills it. The LLC resolves its own AXI traffic.
- One outstanding fetch. Supports whole-cache invalidate for fence.i.

Parameters:
- LINE_COUNT, 32, number of lines; power of two.
- BYTES_PER_LINE, 64, bytes per line; fixed at 64 to match the LLC 512-bit data port.
- INDEX_SIZE, $clog2(LINE_COUNT), index bits.
- OFFSET_SIZE, $clog2(BYTES_PER_LINE), line offset bits.
- TAG_SIZE, 64-INDEX_SIZE-OFFSET_SIZE, tag bits.
- DATA_SIZE, BYTES_PER_LINE*8, line width in bits.

Ports:
- clk  in  1  single clock, all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_valid  in  1  fetch request valid.
- req_addr  in  64  fetch byte address; bits [1:0] ignored.
- req_ready  out  1  cache can accept a request this cycle.
- resp_valid  out  1  instruction word valid.
- resp_inst  out  32  instruction word.
- resp_ready  in  1  fetch consumes the response.
- flush  in  1  one-cycle pulse; invalidate all lines.
- llc_r_addr  out  64  line-aligned address to LLC S_R_ADDR.
- llc_r_addr_valid  out  1  to LLC S_R_ADDR_VALID.
- llc_r_data  in  512  from LLC S_R_DATA.
- llc_r_data_valid  in  1  from LLC S_R_DATA_VALID.
- perf_hits  out  32  hit counter.
- perf_misses  out  32  miss counter.

Behaviour:
- Reset values (async):
  - state=IDLE; all valid bits 0; flush_pending=0.
  - req_ready=0 while reset is asserted, 1 from the first IDLE cycle after reset.
  - resp_valid=0, resp_inst=0.
  - llc_r_addr_valid=0, llc_r_addr=0.
  - perf counters 0.
  - Tag/data storage is not reset.
  - Reset mid-FILL abandons the LLC request. llc_r_addr_valid drops with reset, and no line is written.
- Address split: tag=addr[63:OFFSET_SIZE+INDEX_SIZE], index=addr[OFFSET_SIZE+INDEX_SIZE-1:OFFSET_SIZE], word=addr[OFFSET_SIZE-1:2].
- Word k of a line is data[32k+31:32k]. This matches the LLC fill order, where AXI beat b lands in bits [64b+63:64b].
- State IDLE:
  - req_ready=1 unless flush or flush_pending is asserted.
  - On req_valid&&req_ready, latch req_addr and do a combinational lookup.
  - Hit (valid && tag match): latch the word into resp_inst, go to RESPOND, perf_hits+1.
  - Miss: go to FILL, perf_misses+1.
- State FILL:
  - llc_r_addr={latched tag,index,OFFSET_SIZE'b0} and llc_r_addr_valid=1.
  - Both are held stable every cycle until llc_r_data_valid.
  - In the cycle llc_r_data_valid=1:
    - write line data and tag, set valid;
    - latch the selected word of llc_r_data into resp_inst;
    - go to RESPOND;
    - llc_r_addr_valid=0 from the next cycle.
  - req_ready=0 throughout.
- State RESPOND:
  - resp_valid=1 and resp_inst held stable until resp_ready.
  - On resp_valid&&resp_ready, return to IDLE.
  - A new request is accepted at the earliest in the following cycle.
- Latency:
  - Hit accepted in cycle N gives resp_valid in N+1.
  - Miss accepted in N drives llc_r_addr_valid from N+1. With LLC data in M, resp_valid is in M+1.
- Flush:
  - In IDLE, flush clears all valid bits at the next edge, and req_ready=0 that cycle.
  - flush together with req_valid: flush wins and the request is not accepted.
  - flush in FILL or RESPOND sets flush_pending. The in-flight fill still completes and its response is delivered. The pending flush is applied in the first IDLE cycle (req_ready=0), then flush_pending clears.
  - Fill and flush never both apply to the same line in one cycle.
- Counters: 32-bit, wrap from 0xFFFFFFFF to 0, and are not cleared by flush.
- llc_r_data_valid outside FILL is ignored. The LLC combinationally reports hit status for whatever address is driven, and llc_r_addr_valid=0 outside FILL.

Decomposition:
- cache_pkg holds:
  - the line geometry localparams (BYTES_PER_LINE=64, DATA_SIZE=512);
  - the icache_line_t packed struct {valid, tag, data};
  - the icache_state_t enum {IDLE, FILL, RESPOND};
  - an addr_split function returning tag, index and word.
- Sub-module l1_icache_array holds the line storage with:
  - an async valid-clear port;
  - one combinational lookup port returning hit and word;
  - one synchronous fill port;
  - a flush-all input.
- The FSM and counters stay in l1_icache.

Test Plan:
- Reset, then fetch 0x1000 (miss). llc_r_addr=0x1000 is held until the LLC returns a line whose word k=k+0x100 in data[32k+31:32k]. Expect resp_inst=0x100 one cycle after llc_r_data_valid, and perf_misses=1.
- Fetch 0x1004 next (hit). Expect resp_valid the cycle after acceptance, resp_inst=0x101, no llc_r_addr_valid, perf_hits=1.
- Fetch 0x1000+LINE_COUNT*64 (same index, different tag). Expect a miss, llc_r_addr=0x1800 (defaults), and a refetch of 0x1000 then misses again.
- With resp_ready=0 for 5 cycles after a hit, resp_valid and resp_inst stay stable and req_ready=0. The response completes on the cycle resp_ready=1.
- Assert flush during FILL. The fill completes and is delivered, req_ready=0 for one IDLE cycle, then fetch 0x1004 misses.
- Assert reset asynchronously mid-FILL (LLC stalls 10 cycles). llc_r_addr_valid drops immediately, and the next fetch of the same line misses.
